bd_line_cache: RTL
==================

BD_LINE_CACHE -- requirements
Module: bd_line_cache

Interface
REQ-001 Parameter WORD_W, 32, word width in bits.
REQ-002 Parameter N_WORDS, 16, words per line; line width LINE_W = N_WORDS*WORD_W.
REQ-003 Parameter DELTA_W, 8, signed delta width for compressed storage; DELTA_W < WORD_W.
REQ-004 Parameter DEPTH, 16, number of direct-mapped sets (power of two); IDX_W = $clog2(DEPTH).
REQ-005 Parameter TAG_W, 8, tag width; address width AW = TAG_W+IDX_W.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  invalidate all sets; honoured only in IDLE.
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  block can accept a request.
REQ-011 req_wr  input  1  1 = write line, 0 = read line.
REQ-012 req_addr  input  AW  line address; index = [IDX_W-1:0], tag = [AW-1:IDX_W].
REQ-013 req_data  input  LINE_W  write line; word i = bits [i*WORD_W +: WORD_W].
REQ-014 rsp_valid  output  1  one-cycle response pulse.
REQ-015 rsp_hit  output  1  read: tag match on valid set; write: 1.
REQ-016 rsp_data  output  LINE_W  read line (0 on miss and on write responses).
REQ-017 rsp_compressed  output  1  format of the addressed entry (write: format chosen).
REQ-018 comp_count  output  $clog2(DEPTH+1)  number of valid sets held in compressed format.

Function
REQ-019 Per set state: valid, tag, cflag, storage; compressed storage = base word (word 0) plus N_WORDS signed DELTA_W deltas; raw storage = full line.
REQ-020 FSM states IDLE, SCAN, COMMIT, RLOOK; req_ready = 1 only in IDLE and not during reset.
REQ-021 Handshake: request accepted on the edge where req_valid & req_ready; req_addr/req_data/req_wr captured then; inputs may change afterwards.
REQ-022 flush in IDLE takes priority over req_valid: clear all valid bits, comp_count = 0, req_ready low that cycle, no response.
REQ-023 Write: IDLE -> SCAN; SCAN checks word i at cycle T+1+i for i = 0..N_WORDS-1; delta_i = word_i - word_0 modulo 2^WORD_W, interpreted signed.
REQ-024 Line is compressible iff every delta_i lies in [-2^(DELTA_W-1), 2^(DELTA_W-1)-1]; all-equal and all-zero lines are compressible.
REQ-025 SCAN -> COMMIT after last word; at T+N_WORDS+1 entry written (valid=1, tag, cflag, storage), rsp_valid=1, rsp_hit=1, rsp_compressed=cflag, rsp_data=0; COMMIT -> IDLE.
REQ-026 Write to a set holding a different tag overwrites it silently (no eviction output).
REQ-027 comp_count at commit: +1 if new cflag=1 and old entry not (valid & cflag); -1 if old (valid & cflag) and new cflag=0; otherwise unchanged; visible the cycle after commit.
REQ-028 Read: IDLE -> RLOOK at T+1; rsp_valid at T+2 with rsp_hit = valid & tag match; RLOOK -> IDLE.
REQ-029 Read hit, compressed: word i = base + sign-extend(delta_i) modulo 2^WORD_W; raw: stored line; result bit-identical to the line written.
REQ-030 Read miss: rsp_hit=0, rsp_data=0, rsp_compressed=0; no state change.
REQ-031 rsp_valid, rsp_hit, rsp_compressed, rsp_data are 0 in every cycle without a response.
REQ-032 Back-to-back: next request accepted in the cycle after rsp_valid (FSM back in IDLE).

Reset
REQ-033 reset low asynchronously forces IDLE, all valid = 0, comp_count = 0, req_ready = 0, all rsp_* = 0.
REQ-034 reset asserted during SCAN/COMMIT/RLOOK abandons the operation: no entry written, no response.
REQ-035 req_ready = 1 in the first clock cycle after reset deasserts.

Verification (bench params WORD_W=32, N_WORDS=4, DELTA_W=8, DEPTH=16, TAG_W=4)
REQ-036 Write 0x13 words {0x1000,0x1005,0x0FF0,0x107F} -> rsp_valid at T+5, rsp_compressed=1, comp_count=1; read 0x13 -> at T+2 rsp_hit=1, identical words.
REQ-037 Write 0x05 words {0x0,0x80,0x0,0x0} (delta +128 overflows) -> rsp_compressed=0, comp_count unchanged; readback exact.
REQ-038 Read 0x23 after REQ-036 (index 3, tag 2) -> rsp_hit=0, rsp_data=0; then write 0x13 raw line -> comp_count 1 -> 0.
REQ-039 Write words {0xFFFFFFFF,0x00000005,0xFFFFFF80,0xFFFFFFFF} -> deltas wrap to +6/-127/0, rsp_compressed=1, readback exact.
REQ-040 reset low during SCAN of write 0x13 -> after release req_ready=1 first cycle, read 0x13 misses, comp_count=0.
REQ-041 flush and req_valid together in IDLE -> request not accepted that cycle, all sets miss afterwards, comp_count=0.

Source files
------------

// File: rtl/bd_line_cache.sv
// Direct-mapped line cache that stores each line either raw or as base word plus
// small signed deltas, chosen per line by a word-serial scan on write.
//
// state  | meaning
// IDLE   | ready for a request or a flush
// SCAN   | checking one word per cycle for delta compressibility
// COMMIT | response cycle of a write; entry written at the end of it
// RLOOK  | read lookup cycle, then response cycle
module bd_line_cache #(
   parameter int WORD_W  = 32,
   parameter int N_WORDS = 16,
   parameter int DELTA_W = 8,
   parameter int DEPTH   = 16,
   parameter int TAG_W   = 8,
   localparam int LINE_W = N_WORDS*WORD_W,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int AW     = TAG_W+IDX_W,
   localparam int CW     = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [AW-1:0]     req_addr,
   input  logic [LINE_W-1:0] req_data,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic [LINE_W-1:0] rsp_data,
   output logic              rsp_compressed,
   output logic [CW-1:0]     comp_count
);

   localparam int PACK_W  = WORD_W + N_WORDS*DELTA_W;
   localparam int STORE_W = (PACK_W > LINE_W) ? PACK_W : LINE_W;
   localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic signed [WORD_W-1:0] DMAX = WORD_W'((1 << (DELTA_W-1)) - 1);
   localparam logic signed [WORD_W-1:0] DMIN = ~DMAX;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_RLOOK} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [AW-1:0]       addr_q;
   logic [LINE_W-1:0]   line_q;
   logic                comp_ok;
   logic [DEPTH-1:0]    valid_q;
   logic [DEPTH-1:0]    cflag_q;
   logic [TAG_W-1:0]    tag_mem   [DEPTH];
   logic [STORE_W-1:0]  store_mem [DEPTH];

   logic [IDX_W-1:0]    idx_q;
   logic [TAG_W-1:0]    tag_q;
   logic [WORD_W-1:0]   cur_word;
   logic [WORD_W-1:0]   scan_delta;
   logic                delta_fits;
   logic                old_c;
   logic                rd_hit;
   logic [STORE_W-1:0]  rd_entry;
   logic [LINE_W-1:0]   rd_line;
   logic [STORE_W-1:0]  packed_line;
   logic [STORE_W-1:0]  store_wdata;

   assign idx_q      = addr_q[IDX_W-1:0];
   assign tag_q      = addr_q[AW-1:IDX_W];
   assign cur_word   = line_q[int'(cnt)*WORD_W +: WORD_W];
   assign scan_delta = cur_word - line_q[WORD_W-1:0];
   assign delta_fits = ($signed(scan_delta) <= DMAX) && ($signed(scan_delta) >= DMIN);
   assign old_c      = valid_q[idx_q] & cflag_q[idx_q];
   assign rd_hit     = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
   assign req_ready  = (state == S_IDLE) && reset && !flush;

   // Only the low DELTA_W bits of each difference are kept; the scan guarantees
   // they sign-extend back to the full difference.
   always_comb begin
      packed_line = '0;
      packed_line[WORD_W-1:0] = line_q[WORD_W-1:0];
      for (int i = 0; i < N_WORDS; i++) begin
         packed_line[WORD_W+i*DELTA_W +: DELTA_W] =
            line_q[i*WORD_W +: DELTA_W] - line_q[DELTA_W-1:0];
      end
      store_wdata = comp_ok ? packed_line : STORE_W'(line_q);
   end

   always_comb begin
      rd_entry = store_mem[idx_q];
      rd_line  = '0;
      if (cflag_q[idx_q]) begin
         for (int i = 0; i < N_WORDS; i++) begin
            rd_line[i*WORD_W +: WORD_W] = rd_entry[WORD_W-1:0] +
               {{(WORD_W-DELTA_W){rd_entry[WORD_W+i*DELTA_W+DELTA_W-1]}},
                rd_entry[WORD_W+i*DELTA_W +: DELTA_W]};
         end
      end else begin
         rd_line = rd_entry[LINE_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         addr_q         <= '0;
         line_q         <= '0;
         comp_ok        <= 1'b0;
         valid_q        <= '0;
         cflag_q        <= '0;
         comp_count     <= '0;
         rsp_valid      <= 1'b0;
         rsp_hit        <= 1'b0;
         rsp_data       <= '0;
         rsp_compressed <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (flush) begin
                  valid_q    <= '0;
                  comp_count <= '0;
               end else if (req_valid) begin
                  addr_q  <= req_addr;
                  line_q  <= req_data;
                  cnt     <= '0;
                  comp_ok <= 1'b1;
                  state   <= req_wr ? S_SCAN : S_RLOOK;
               end
            end
            S_SCAN: begin
               comp_ok <= comp_ok & delta_fits;
               if (cnt == CNT_W'(N_WORDS-1)) begin
                  state          <= S_COMMIT;
                  rsp_valid      <= 1'b1;
                  rsp_hit        <= 1'b1;
                  rsp_data       <= '0;
                  rsp_compressed <= comp_ok & delta_fits;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_COMMIT: begin
               valid_q[idx_q] <= 1'b1;
               cflag_q[idx_q] <= comp_ok;
               if (comp_ok && !old_c)
                  comp_count <= comp_count + CW'(1);
               else if (old_c && !comp_ok)
                  comp_count <= comp_count - CW'(1);
               rsp_valid      <= 1'b0;
               rsp_hit        <= 1'b0;
               rsp_compressed <= 1'b0;
               state          <= S_IDLE;
            end
            S_RLOOK: begin
               // cnt 0: lookup cycle; cnt 1: response cycle
               if (cnt == '0) begin
                  cnt            <= CNT_W'(1);
                  rsp_valid      <= 1'b1;
                  rsp_hit        <= rd_hit;
                  rsp_data       <= rd_hit ? rd_line : '0;
                  rsp_compressed <= rd_hit & cflag_q[idx_q];
               end else begin
                  rsp_valid      <= 1'b0;
                  rsp_hit        <= 1'b0;
                  rsp_data       <= '0;
                  rsp_compressed <= 1'b0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_COMMIT) begin
         tag_mem[idx_q]   <= tag_q;
         store_mem[idx_q] <= store_wdata;
      end
   end

endmodule
